// File: rtl/elevator_pkg.sv
// Shared elevator constants, used by both the call request unit and the
// elevator controller so that floor encodings always agree.
//
// Contents:
//   NUM_FLOORS     number of served floors (3)
//   FLOOR1..FLOOR3 one-hot floor codes as driven on the controller's floor bus
//   floor_code()   floor number -> one-hot code, for use in generate loops
package elevator_pkg;

    localparam int NUM_FLOORS = 3;

    localparam logic [NUM_FLOORS:1] FLOOR1 = 3'b001;
    localparam logic [NUM_FLOORS:1] FLOOR2 = 3'b010;
    localparam logic [NUM_FLOORS:1] FLOOR3 = 3'b100;

    function automatic logic [NUM_FLOORS:1] floor_code(input int floor_num);
        case (floor_num)
            1:       return FLOOR1;
            2:       return FLOOR2;
            3:       return FLOOR3;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single call button conditioner: two-flop synchroniser, optional debounce
// filter and rising-edge detector.
//
// Configuration macro: CALL_DEBOUNCE_EN
//   defined   - debounce filter present; the level flips after DEBOUNCE_CYCLES
//               consecutive cycles of disagreement with the synchronised input
//   undefined - the synchronised level is used directly, no counter exists
//
// Ports:
//   clk    in   rising-edge system clock
//   RESET  in   asynchronous, active-high reset
//   raw    in   raw, unsynchronised button level
//   press  out  one-cycle pulse on each accepted press (debounced rising edge)
module btn_debounce
`ifdef CALL_DEBOUNCE_EN
    #(parameter int unsigned DEBOUNCE_CYCLES = 4)
`endif
(
    input  logic clk,
    input  logic RESET,
    input  logic raw,
    output logic press
);

    logic sync_meta;
    logic sync_level;
    logic level;
    logic level_d;

    // NOTE: every register uses non-blocking assignment so the two synchroniser
    // stages shift by exactly one flop per edge regardless of statement order.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= raw;
            sync_level <= sync_meta;
        end
    end

`ifdef CALL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // The counter never reaches DEBOUNCE_CYCLES: the edge that would take it
    // there flips the level and clears it instead, so it cannot wrap.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_level == level) begin
            cnt   <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync_level;
        end else begin
            cnt   <= cnt + CNT_ONE;
        end
    end
`else
    assign level = sync_level;
`endif

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // NOTE: the pulse is decoded from flops rather than registered again, so
    // the call latch sees it one edge after the level rises, not two.
    assign press = level & ~level_d;

endmodule

// File: rtl/call_request_unit.sv
// Floor call request unit: conditions the raw hall-call buttons and holds a
// pending-call vector for the elevator controller. A call is latched on an
// accepted press and cleared when the car reports that floor; clearing wins
// over a simultaneous press.
//
// Configuration macro: CALL_DEBOUNCE_EN (enables the debounce filter and the
// DEBOUNCE_CYCLES parameter, legal range 1..255).
//
// Ports:
//   clk        in   rising-edge system clock
//   RESET      in   asynchronous, active-high reset
//   btn_raw    in   [3:1] raw call buttons, bit n = floor n
//   floor_at   in   [3:1] one-hot car floor; zero or non-one-hot = no floor
//   call       out  [3:1] registered pending-call vector
//   call_any   out  OR of call
//   press_evt  out  [3:1] one-cycle pulse per accepted press, unmasked
module call_request_unit
    import elevator_pkg::*;
`ifdef CALL_DEBOUNCE_EN
    #(parameter int unsigned DEBOUNCE_CYCLES = 4)
`endif
(
    input  logic                  clk,
    input  logic                  RESET,
    input  logic [NUM_FLOORS:1]   btn_raw,
    input  logic [NUM_FLOORS:1]   floor_at,
    output logic [NUM_FLOORS:1]   call,
    output logic                  call_any,
    output logic [NUM_FLOORS:1]   press_evt
);

    logic [NUM_FLOORS:1] clear;

    for (genvar n = 1; n <= NUM_FLOORS; n++) begin : g_floor
        btn_debounce
`ifdef CALL_DEBOUNCE_EN
            #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
        u_btn (
            .clk   (clk),
            .RESET (RESET),
            .raw   (btn_raw[n]),
            .press (press_evt[n])
        );

        // Exact match against the floor code: an idle or corrupt floor bus
        // matches no floor and therefore clears nothing.
        assign clear[n] = (floor_at == floor_code(n));
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            call <= '0;
        end else begin
            call <= (call | press_evt) & ~clear;
        end
    end

    assign call_any = |call;

endmodule

// File: tb/tb_call_request_unit.sv
// Self-checking bench for call_request_unit. Directed scenarios followed by
// randomised button/floor activity, all compared cycle by cycle against a
// behavioural model that works from sampled button history.
module tb_call_request_unit;

`ifdef CALL_DEBOUNCE_EN
    localparam int D    = 4;
    localparam int LAT  = 3 + D;
    localparam int HIST = D + 2;
`else
    localparam int LAT  = 3;
    localparam int HIST = 2;
`endif

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:1] btn_raw;
    logic [3:1] floor_at;
    logic [3:1] call;
    logic       call_any;
    logic [3:1] press_evt;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [3:1] m_deb;
    logic [3:1] m_press;
    logic [3:1] m_call;
    logic [3:1] hist[$];   // hist[j] = btn_raw sampled j edges ago (0 = this edge)

    always #5 clk = ~clk;

`ifdef CALL_DEBOUNCE_EN
    call_request_unit #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .RESET     (RESET),
        .btn_raw   (btn_raw),
        .floor_at  (floor_at),
        .call      (call),
        .call_any  (call_any),
        .press_evt (press_evt)
    );
`else
    call_request_unit dut (
        .clk       (clk),
        .RESET     (RESET),
        .btn_raw   (btn_raw),
        .floor_at  (floor_at),
        .call      (call),
        .call_any  (call_any),
        .press_evt (press_evt)
    );
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_deb   = '0;
        m_press = '0;
        m_call  = '0;
        hist.delete();
        for (int j = 0; j < HIST; j++) hist.push_back('0);
    endfunction

    // One rising edge of the reference behaviour, using the inputs present
    // just before the edge.
    function automatic void model_edge();
        logic [3:1] clr;
        logic [3:1] nxt;
        logic [3:1] diff;
        clr    = ($countones(floor_at) == 1) ? floor_at : 3'b000;
        m_call = (m_call | m_press) & ~clr;
        hist.push_front(btn_raw);
        void'(hist.pop_back());
`ifdef CALL_DEBOUNCE_EN
        // Flip a level once the last D synchronised samples all disagree with it.
        diff = 3'b111;
        for (int j = 2; j <= D + 1; j++) diff &= hist[j] ^ m_deb;
        nxt = m_deb ^ diff;
`else
        diff = 3'b000;
        nxt  = hist[1] | diff;
`endif
        m_press = nxt & ~m_deb;
        m_deb   = nxt;
    endfunction

    // Advance one clock, then compare all outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("press_evt", press_evt, m_press);
        check("call", call, m_call);
        check("call_any", call_any, |m_call);
    endtask

    task automatic step_n(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Called on a falling edge; returns on the falling edge after release.
    task automatic do_reset();
        RESET = 1'b1;
        #1;
        check("rst_call", call, 3'b000);
        check("rst_press", press_evt, 3'b000);
        check("rst_any", call_any, 1'b0);
        model_reset();
        @(negedge clk);
        RESET = 1'b0;
    endtask

    int pulses;
    int seg_len;
    logic [3:1] fsel;

    initial begin
        RESET    = 1'b1;
        btn_raw  = '0;
        floor_at = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single press on floor 3 while the car sits at floor 1.
        btn_raw  = 3'b100;
        floor_at = 3'b001;
        pulses   = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (press_evt[3]) pulses++;
            if (e == LAT - 1) check("f3_before", call, 3'b000);
            if (e == LAT) begin
                check("f3_call", call, 3'b100);
                check("f3_any", call_any, 1'b1);
            end
        end
        check("f3_pulses", pulses, 1);

        // Short glitch on floor 2.
        do_reset();
        btn_raw  = 3'b010;
        floor_at = 3'b000;
        pulses   = 0;
        for (int e = 1; e <= 12; e++) begin
            if (e == 4) btn_raw = 3'b000;
            step();
            if (press_evt != 3'b000) pulses++;
        end
`ifdef CALL_DEBOUNCE_EN
        check("glitch_pulses", pulses, 0);
        check("glitch_call", call, 3'b000);
`endif

        // Two pending calls, car arrives at floor 2 then floor 3.
        do_reset();
        btn_raw  = 3'b110;
        floor_at = 3'b000;
        step_n(LAT);
        check("two_call", call, 3'b110);
        btn_raw = 3'b000;
        step_n(LAT + 2);
        floor_at = 3'b010;
        step();
        check("clr_f2", call, 3'b100);
        floor_at = 3'b100;
        step();
        check("clr_f3", call, 3'b000);

        // Press at the car's own floor is masked; same press with no floor latches.
        do_reset();
        btn_raw  = 3'b001;
        floor_at = 3'b001;
        pulses   = 0;
        for (int e = 1; e <= LAT + 2; e++) begin
            step();
            if (press_evt[1]) pulses++;
        end
        check("mask_pulses", pulses, 1);
        check("mask_call", call, 3'b000);
        btn_raw = 3'b000;
        step_n(LAT + 2);
        floor_at = 3'b000;
        btn_raw  = 3'b001;
        step_n(LAT);
        check("nofloor_call", call, 3'b001);

        // Reset in the middle of debouncing a held button.
        do_reset();
        btn_raw  = 3'b100;
        floor_at = 3'b000;
        step_n(4);
        do_reset();
        step_n(LAT - 1);
        check("rst_mid_before", call, 3'b000);
        step();
        check("rst_mid_call", call, 3'b100);

        // Simultaneous presses latch together.
        do_reset();
        btn_raw = 3'b011;
        step_n(LAT - 1);
        check("dual_before", call, 3'b000);
        step();
        check("dual_call", call, 3'b011);

        // Randomised activity.
        do_reset();
        for (int s = 0; s < 150; s++) begin
            btn_raw = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0, 1, 2: fsel = 3'b000;
                3:       fsel = 3'b001;
                4:       fsel = 3'b010;
                5:       fsel = 3'b100;
                6:       fsel = 3'b011;
                default: fsel = 3'b111;
            endcase
            floor_at = fsel;
            seg_len  = $urandom_range(1, 10);
            if ($urandom_range(0, 39) == 0) do_reset();
            step_n(seg_len);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/call_request_unit.md
CALL_REQUEST_UNIT -- requirements
Module: call_request_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles required to accept a button level change (legal range 1..255).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port btn_raw  input  [3:1]  raw, unsynchronised floor call buttons; bit n = floor n.
REQ-005 SHALL have port floor_at  input  [3:1]  current car floor from the elevator controller, one-hot; bit n = car at floor n.
REQ-006 SHALL have port call  output  [3:1]  registered pending-call vector that drives the controller's request inputs.
REQ-007 SHALL have port call_any  output  1  OR of call[3:1].
REQ-008 SHALL have port press_evt  output  [3:1]  single-cycle pulse per accepted press (before floor masking).

Function
REQ-009 SHALL pass each btn_raw bit through a two-flop synchroniser before any other use.
REQ-010 SHALL keep a debounced level per button; a per-button counter SHALL count cycles in which the synchronised level differs from the debounced level, and SHALL clear to 0 whenever they match.
REQ-011 SHALL flip the debounced level on the edge where the counter would reach DEBOUNCE_CYCLES; counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)) bits with no wrap.
REQ-012 SHALL assert press_evt[n] for exactly one cycle when debounced level n rises; debounced falling edges produce no event.
REQ-013 SHALL set call[n] on the clock edge after press_evt[n], i.e. at rising edge 3+DEBOUNCE_CYCLES after btn_raw[n] goes and stays high.
REQ-014 SHALL hold call[n] set until cleared; repeated presses while set have no further effect.
REQ-015 SHALL clear call[n] on the edge where floor_at equals the one-hot code of floor n.
REQ-016 SHALL give clear priority: press_evt[n] coinciding with floor_at one-hot at floor n leaves call[n] = 0.
REQ-017 SHALL treat floor_at = 3'b000 or any non-one-hot value as "no floor": no clears occur, and presses are latched normally.
REQ-018 SHALL process the three floors independently; simultaneous presses on several floors SHALL all latch on the same edge.
REQ-019 SHALL drive call_any combinationally from the call register only.

Reset
REQ-020 SHALL, on RESET high, asynchronously force synchronisers, debounced levels, counters, edge-detect flops and call to 0; press_evt and call_any SHALL read 0.
REQ-021 SHALL discard any partly debounced press when RESET asserts mid-count; a button still held after release of RESET SHALL be re-accepted after the full 3+DEBOUNCE_CYCLES edges.

Configuration
REQ-022 SHALL implement macro CALL_DEBOUNCE_EN: when defined, the debounce filter of REQ-010/011 is compiled in.
REQ-023 SHALL, when CALL_DEBOUNCE_EN is undefined, omit the counters and DEBOUNCE_CYCLES, use the synchronised level as the debounced level, and give call[n] at rising edge 3 after the button press; all other requirements are unchanged.

Structure
REQ-024 SHALL take NUM_FLOORS (3) and the floor one-hot constants FLOOR1/FLOOR2/FLOOR3 from the shared package elevator_pkg; the elevator controller uses the same constants.
REQ-025 SHALL implement per-button synchronisation, debounce and rising-edge detection in sub-module btn_debounce, instantiated once per floor; the call register and clear logic stay in the top module.

Verification
REQ-026 SHALL cover: DEBOUNCE_CYCLES=4, btn_raw=3'b100 held 10 cycles, floor_at=3'b001 -> press_evt[3] pulses once, call=3'b100 at edge 7, call_any=1.
REQ-027 SHALL cover: 3-cycle glitch on btn_raw[2] -> no press_evt, call stays 3'b000.
REQ-028 SHALL cover: call=3'b110 pending, floor_at changes to 3'b010 -> call=3'b100 on the next edge.
REQ-029 SHALL cover: btn_raw[1] held while floor_at=3'b001 -> press_evt[1] pulses, call[1] stays 0; with floor_at=3'b000 the same press gives call[1]=1.
REQ-030 SHALL cover: RESET pulsed at debounce count 2 with btn_raw[3] held -> all outputs 0 immediately; call[3]=1 at edge 7 after RESET release.
REQ-031 SHALL cover: build without CALL_DEBOUNCE_EN, btn_raw=3'b011 -> call=3'b011 at edge 3.
